// File: rtl/approx_mul_acc_stage.sv
// Purpose : sums a frame of approximate-multiplier products and presents sum, beat count and overflow flag.
// Latency : result valid the cycle after the in_last beat is accepted; held until out_ready.
// Backpressure: in_ready drops while a frame result waits for out_ready; beats are stalled, never dropped.
//
// Ports:
//   clk, rst_n                      rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_prod/in_last   product beat handshake (PROD_W-bit zero-extended product)
//   out_valid/out_ready             frame result handshake
//   out_sum [ACC_W], out_count [CNT_W], out_ovf   frame result (count saturates, ovf sticky per frame)
//
// Build option: define APPROX_ACC_SAT_EN to clamp the accumulator at all-ones after a carry out;
// left undefined, the accumulator wraps modulo 2^ACC_W. out_ovf is raised in both builds.
module approx_mul_acc_stage #(
    parameter int PROD_W = 24,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             beat;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    // Gated by rst_n so the stage never advertises room while held in reset.
    assign in_ready = rst_n && (state != HOLD);
    assign beat     = in_valid && in_ready;

    // One extra bit captures the carry out of the ACC_W-bit accumulator.
    assign sum_ext = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, in_prod};
    assign carry   = sum_ext[ACC_W];
    assign ovf_nxt = ovf || carry;

`ifdef APPROX_ACC_SAT_EN
    // Once the frame has overflowed, the accumulator stays pinned at all-ones.
    assign acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

    assign cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (beat) begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (in_last) begin
                            // Result registers take the final beat's contribution directly.
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_sum   <= acc_nxt;
                            out_count <= cnt_nxt;
                            out_ovf   <= ovf_nxt;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    // out_valid is always 1 here, so out_ready alone completes the handshake.
                    // out_sum/out_count/out_ovf keep their value after it.
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mul_acc_stage.sv
// Purpose : directed and throttled-random checks of approx_mul_acc_stage.
// Latency : inputs driven and outputs sampled on the falling edge, away from the active edge.
// Backpressure: the bench drives out_ready low to hold results and stall the producer.
module tb_approx_mul_acc_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default-width instance (ACC_W = 32)
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [23:0] in_prod;
    logic [31:0] out_sum;
    logic [9:0]  out_count;

    // Narrow instance (ACC_W = 24) for overflow behaviour
    logic        nar_in_valid, nar_in_ready, nar_in_last, nar_out_valid, nar_out_ready, nar_out_ovf;
    logic [23:0] nar_in_prod;
    logic [23:0] nar_out_sum;
    logic [9:0]  nar_out_count;

    approx_mul_acc_stage #(.PROD_W(24), .ACC_W(32), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    approx_mul_acc_stage #(.PROD_W(24), .ACC_W(24), .CNT_W(10)) dut_nar (
        .clk(clk), .rst_n(rst_n),
        .in_valid(nar_in_valid), .in_ready(nar_in_ready), .in_prod(nar_in_prod), .in_last(nar_in_last),
        .out_valid(nar_out_valid), .out_ready(nar_out_ready),
        .out_sum(nar_out_sum), .out_count(nar_out_count), .out_ovf(nar_out_ovf)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one beat (called at a falling edge) and returns at the falling edge after acceptance.
    task automatic send(input bit nar, input logic [23:0] p, input logic l);
        int guard;
        bit took;
        guard = 0;
        if (nar) begin nar_in_valid = 1'b1; nar_in_prod = p; nar_in_last = l; end
        else     begin in_valid     = 1'b1; in_prod     = p; in_last     = l; end
        do begin
            took = nar ? nar_in_ready : in_ready;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end while (!took && guard < 100);
        chk("beat_accepted", 64'(took), 64'd1);
        if (nar) nar_in_valid = 1'b0;
        else     in_valid     = 1'b0;
    endtask

    typedef struct {
        int               n;
        logic [3:0][23:0] prod;
        logic [31:0]      sum;
        logic [9:0]       cnt;
        logic             ovf;
    } vec_t;

    vec_t vt [5];

    typedef struct {
        logic [31:0] sum;
        logic [9:0]  cnt;
    } exp_t;

    exp_t exp_q [$];

    initial begin
        vt[0] = '{3, {24'h000000, 24'h003000, 24'h002000, 24'h001000}, 32'h0000_6000, 10'd3, 1'b0};
        vt[1] = '{1, {24'h000000, 24'h000000, 24'h000000, 24'hFFF000}, 32'h00FF_F000, 10'd1, 1'b0};
        vt[2] = '{4, {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 32'h03FF_FFFC, 10'd4, 1'b0};
        vt[3] = '{2, {24'h000000, 24'h000000, 24'h000000, 24'h000000}, 32'h0000_0000, 10'd2, 1'b0};
        vt[4] = '{2, {24'h000000, 24'h000000, 24'h000001, 24'h123456}, 32'h0012_3457, 10'd2, 1'b0};

        in_valid = 0; in_prod = '0; in_last = 0; out_ready = 1;
        nar_in_valid = 0; nar_in_prod = '0; nar_in_last = 0; nar_out_ready = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven frames, consumer always ready
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < vt[i].n; j++)
                send(1'b0, vt[i].prod[j], j == vt[i].n - 1);
            chk("tbl_out_valid", 64'(out_valid), 64'd1);
            chk("tbl_out_sum", 64'(out_sum), 64'(vt[i].sum));
            chk("tbl_out_count", 64'(out_count), 64'(vt[i].cnt));
            chk("tbl_out_ovf", 64'(out_ovf), 64'(vt[i].ovf));
            @(negedge clk);
            chk("tbl_valid_one_cycle", 64'(out_valid), 64'd0);
            chk("tbl_sum_retained", 64'(out_sum), 64'(vt[i].sum));
            chk("tbl_in_ready_back", 64'(in_ready), 64'd1);
        end

        // 24-bit accumulator overflow: two-beat and three-beat frames, then a clean frame
        send(1'b1, 24'hFFF000, 1'b0);
        send(1'b1, 24'h002000, 1'b1);
        chk("ovf2_valid", 64'(nar_out_valid), 64'd1);
`ifdef APPROX_ACC_SAT_EN
        chk("ovf2_sum", 64'(nar_out_sum), 64'hFFFFFF);
`else
        chk("ovf2_sum", 64'(nar_out_sum), 64'h001000);
`endif
        chk("ovf2_count", 64'(nar_out_count), 64'd2);
        chk("ovf2_flag", 64'(nar_out_ovf), 64'd1);
        @(negedge clk);
        send(1'b1, 24'hFFF000, 1'b0);
        send(1'b1, 24'h002000, 1'b0);
        send(1'b1, 24'h000010, 1'b1);
`ifdef APPROX_ACC_SAT_EN
        chk("ovf3_sum", 64'(nar_out_sum), 64'hFFFFFF);
`else
        chk("ovf3_sum", 64'(nar_out_sum), 64'h001010);
`endif
        chk("ovf3_count", 64'(nar_out_count), 64'd3);
        chk("ovf3_flag", 64'(nar_out_ovf), 64'd1);
        @(negedge clk);
        send(1'b1, 24'h000100, 1'b1);
        chk("ovf_clear_sum", 64'(nar_out_sum), 64'h000100);
        chk("ovf_clear_flag", 64'(nar_out_ovf), 64'd0);
        @(negedge clk);

        // Result held for 5 cycles with a stalled next beat
        out_ready = 0;
        send(1'b0, 24'h000010, 1'b0);
        send(1'b0, 24'h000020, 1'b1);
        in_valid = 1; in_prod = 24'h000400; in_last = 1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_out_sum", 64'(out_sum), 64'h30);
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_count_kept", 64'(out_count), 64'd2);
        @(negedge clk);
        in_valid = 0;
        chk("stalled_beat_valid", 64'(out_valid), 64'd1);
        chk("stalled_beat_sum", 64'(out_sum), 64'h400);
        chk("stalled_beat_count", 64'(out_count), 64'd1);
        @(negedge clk);
        chk("stalled_beat_done", 64'(out_valid), 64'd0);

        // Beat counter saturation
        for (int k = 0; k < 1030; k++)
            send(1'b0, 24'h000001, k == 1029);
        chk("sat_cnt_sum", 64'(out_sum), 64'd1030);
        chk("sat_cnt_count", 64'(out_count), 64'd1023);
        chk("sat_cnt_ovf", 64'(out_ovf), 64'd0);
        @(negedge clk);

        // Reset mid-frame
        send(1'b0, 24'h000100, 1'b0);
        send(1'b0, 24'h000200, 1'b0);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_sum", 64'(out_sum), 64'd0);
        chk("midrst_out_count", 64'(out_count), 64'd0);
        chk("midrst_out_ovf", 64'(out_ovf), 64'd0);
        repeat (2) @(negedge clk);
        chk("midrst_no_pulse", 64'(out_valid), 64'd0);
        rst_n = 1;
        @(negedge clk);
        send(1'b0, 24'h000800, 1'b1);
        chk("after_rst_valid", 64'(out_valid), 64'd1);
        chk("after_rst_sum", 64'(out_sum), 64'h800);
        chk("after_rst_count", 64'(out_count), 64'd1);
        @(negedge clk);

        // Throttled random frames against a reference sum/count model
        fork
            begin : producer
                for (int f = 0; f < 1000; f++) begin
                    int   n;
                    exp_t e;
                    n = int'($urandom_range(1, 6));
                    e.sum = '0;
                    e.cnt = 10'(n);
                    for (int j = 0; j < n; j++) begin
                        logic [23:0] p;
                        p = 24'($urandom_range(0, 32'hFF_FFFF));
                        e.sum = e.sum + {8'h00, p};
                        if (j == n - 1) exp_q.push_back(e);
                        if ($urandom_range(0, 3) == 0) @(negedge clk);
                        send(1'b0, p, j == n - 1);
                    end
                end
            end
            begin : consumer
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < 1000 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        chk("rand_expect_pending", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("rand_sum", 64'(out_sum), 64'(e.sum));
                            chk("rand_count", 64'(out_count), 64'(e.cnt));
                            chk("rand_ovf", 64'(out_ovf), 64'd0);
                        end
                        got++;
                    end
                end
                chk("rand_frames_received", 64'(got), 64'd1000);
            end
        join
        out_ready = 1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
